blob_stream_tx: RTL
===================

// Module: blob_stream_tx
// PURPOSE
//  Transmit side of the inter-layer blob stream (en/eop/rdy). Reads one frame of FRAME_LEN words
//  from a 1-cycle-latency sync RAM read port and emits them on blob_dout_*, which feeds a layer's
//  blob_din_* inputs (e.g. pool2 input: 8x8x8 = 512 words). Sits between a feature-map buffer and
//  the first layer of a chain. Uses a small internal prefetch FIFO so the output can sustain 1 word/cycle.
// PARAMETERS
//  DW         16   data word width
//  AW         10   memory address width
//  FRAME_LEN  512  words per frame, 1..2^AW
//  BUF_DEPTH  4    prefetch FIFO entries, power of 2, >=2
// PORTS
//  clk            in   1    clock, all logic on rising edge
//  rst            in   1    asynchronous active-low reset
//  start          in   1    1-cycle pulse: begin frame at base_addr (ignored while busy)
//  base_addr      in   AW   first word address, sampled when start is accepted
//  busy           out  1    high from accepted start until the done pulse, inclusive
//  done           out  1    1-cycle pulse after the eop word has been transferred
//  mem_rd_en      out  1    RAM read strobe
//  mem_rd_addr    out  AW   RAM read address (wraps modulo 2^AW)
//  mem_rd_data    in   DW   RAM data, valid the cycle after mem_rd_en
//  blob_dout_rdy  in   1    receiver can accept a word this cycle
//  blob_dout_en   out  1    word transferred this cycle
//  blob_dout_eop  out  1    last word of frame, only ever high together with blob_dout_en
//  blob_dout      out  DW   output word
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, FIFO empty, counters 0, in-flight flag 0. Outputs busy, done,
//   mem_rd_en, blob_dout_en, blob_dout_eop = 0; mem_rd_addr = 0; blob_dout = 0.
//   Reset mid-frame abandons the frame: no eop, no done.
//  Handshake: blob_dout_en = blob_dout_rdy & ~fifo_empty (combinational from rdy).
//   - en never high while rdy is low.
//   - Every en cycle is exactly one transferred word; no separate ack.
//   - blob_dout is the FIFO head (registered) and holds while rdy is low.
//  FSM:
//   - IDLE -> RUN on start.
//   - RUN -> DRAIN after the read for word FRAME_LEN-1 is issued.
//   - DRAIN -> DONE when the eop word pops.
//   - DONE -> IDLE after 1 cycle, with done=1 during that cycle.
//   - start outside IDLE is ignored.
//  Read issue in RUN: mem_rd_en = (fifo_count + inflight) < BUF_DEPTH. rd_cnt and mem_rd_addr
//   increment per issued read. mem_rd_data is pushed into the FIFO the cycle after mem_rd_en.
//   Push and pop in the same cycle leave the count unchanged. The FIFO never overflows and never
//   drops data.
//  eop: a pop-side counter counts transferred words; eop=1 on the en cycle where it equals FRAME_LEN-1.
//  Latency: start at cycle T -> mem_rd_en at T+1 -> earliest blob_dout_en at T+3 (rdy held high).
//   With rdy held high, words are transferred on consecutive cycles: FRAME_LEN en cycles from T+3,
//   eop at T+2+FRAME_LEN, done at T+3+FRAME_LEN.
//  Address: mem_rd_addr = base_addr + rd_cnt, modulo 2^AW (wraps from 2^AW-1 to 0).
//  FRAME_LEN=1: RUN issues a single read then goes straight to DRAIN; that word carries en and eop together.
//  A start arriving in the same cycle as done is ignored; a new start is accepted from the next (IDLE) cycle.
// TESTING
//  1 Full-rate frame: RAM[a]=a, base=0, FRAME_LEN=512, rdy=1 -> 512 consecutive en, words 0..511,
//    eop only on word 511, done one cycle later, busy low afterwards.
//  2 Backpressure: rdy random at 30% high -> en never high while rdy=0, words in order 0..511,
//    the mem_rd_en/FIFO-count invariant holds (never overflows), exactly 1 eop and 1 done.
//  3 Address wrap: AW=10, base=1000, FRAME_LEN=32 -> addresses 1000..1023 then 0..7, data in that order.
//  4 Ignored start: pulse start at T+10 and at the done cycle -> no restart, word count stays 512.
//    Then a start at done+1 begins a second identical frame.
//  5 Reset mid-frame: rst=0 after word 100 -> all outputs 0 immediately, no eop/done.
//    After release, a new start gives a clean frame 0..511.
//  6 FRAME_LEN=1, rdy held low for 5 cycles after the read -> no en while low;
//    then a single en+eop word, done on the next cycle.

Source files
------------

// File: rtl/blob_stream_tx.sv
// blob_stream_tx
//   Transmit side of the inter-layer blob stream. On an accepted start, reads
//   FRAME_LEN consecutive words from a synchronous RAM with 1-cycle read latency,
//   beginning at base_addr. The address wraps modulo 2^AW. The words go out on
//   blob_dout* through a small prefetch FIFO, so the stream can sustain one word
//   per cycle.
//
// Ports
//   clk, rst        clock (rising edge); asynchronous active-low reset
//   start           1-cycle pulse, accepted only in IDLE; base_addr sampled then
//   busy            high from the accepted start through the done cycle
//   done            1-cycle pulse, the cycle after the eop word transferred
//   mem_rd_en/addr  RAM read strobe and address
//   mem_rd_data     RAM data, valid the cycle after mem_rd_en
//   blob_dout_rdy   receiver can take a word this cycle
//   blob_dout_en    word transferred this cycle
//   blob_dout_eop   last word of the frame (only together with blob_dout_en)
//   blob_dout       output word (FIFO head)
//   state_dbg       current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//
// Handshake: blob_dout_en = blob_dout_rdy & FIFO-not-empty, combinational from
//   rdy. Every cycle with en high is exactly one transferred word, with no
//   separate ack. While rdy is low, en stays low and blob_dout holds the head word.
module blob_stream_tx #(
  parameter int DW        = 16,
  parameter int AW        = 10,
  parameter int FRAME_LEN = 512,
  parameter int BUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  input  logic          blob_dout_rdy,
  output logic          blob_dout_en,
  output logic          blob_dout_eop,
  output logic [DW-1:0] blob_dout,
  output logic [1:0]    state_dbg
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [AW:0] LAST    = (AW+1)'(FRAME_LEN - 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q;
  logic [AW:0]   rd_cnt_q;
  logic [AW:0]   pop_cnt_q;
  logic          inflight_q;
  logic [DW-1:0] fifo_mem [BUF_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_empty, push, pop, accept;
  logic [CW:0]   occupancy;

  assign fifo_empty    = (count_q == '0);
  assign push          = inflight_q;
  assign pop           = blob_dout_en;
  assign accept        = (state_q == S_IDLE) && start;

  // A read in flight already owns a FIFO slot, so it counts toward occupancy.
  // This keeps the FIFO from overflowing even when rdy stalls.
  assign occupancy     = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign mem_rd_en     = (state_q == S_RUN) && (occupancy < DEPTH_W);
  assign mem_rd_addr   = base_q + rd_cnt_q[AW-1:0];

  assign blob_dout_en  = blob_dout_rdy && !fifo_empty;
  assign blob_dout_eop = blob_dout_en && (pop_cnt_q == LAST);
  assign blob_dout     = fifo_mem[rd_ptr_q];

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign state_dbg     = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (mem_rd_en && (rd_cnt_q == LAST)) state_d = S_DRAIN;
      S_DRAIN: if (blob_dout_eop) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Frame counters: rd_cnt tracks issued reads, pop_cnt tracks transferred words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q     <= '0;
      rd_cnt_q   <= '0;
      pop_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= mem_rd_en;
      if (accept) begin
        base_q    <= base_addr;
        rd_cnt_q  <= '0;
        pop_cnt_q <= '0;
      end else begin
        if (mem_rd_en) rd_cnt_q  <= rd_cnt_q + 1'b1;
        if (pop)       pop_cnt_q <= pop_cnt_q + 1'b1;
      end
    end
  end

  // Prefetch FIFO. The storage is reset so that blob_dout reads 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= mem_rd_data;
        wr_ptr_q           <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

endmodule
